// File: rtl/morse_fifo.sv
// morse_fifo: single-clock FIFO between the UART receiver (writer) and the
// Morse encoder (reader). It keeps its own read/write pointers and fill count,
// reports empty/full/almost-full status, and latches overflow/underflow events.
// The read port is registered and read-first, so a pop and a push to the same
// entry in one cycle return the entry's old contents.
module morse_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int AF_MARGIN = 4
) (
    input  logic              i_clk_24,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow,
    input  logic              i_clr_err
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam int              AF_TH_I = DEPTH - AF_MARGIN;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_TH   = AF_TH_I[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    logic              wr_ok;
    logic              rd_ok;

    // Acceptance, pointer/count next state, and status derived from the next count
    always_comb begin
        rd_ok   = i_rd & ~i_rst & ~empty_q;
        wr_ok   = i_wr & ~i_rst & (~full_q | rd_ok);
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (wr_ok) begin
            wp_d = wp_q + ADDR_W'(1);
        end
        if (rd_ok) begin
            rp_d = rp_q + ADDR_W'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        af_d    = (count_d >= AF_TH);
        // an event in the same cycle as a clear wins, so the flag ends set
        ovf_d   = (ovf_q & ~i_clr_err) | (i_wr & ~wr_ok);
        udf_d   = (udf_q & ~i_clr_err) | (i_rd & empty_q);
    end

    // Control and status registers
    always_ff @(posedge i_clk_24) begin
        if (i_rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            valid_q <= rd_ok;
        end
    end

    // Storage write port; contents are deliberately left uninitialised on reset
    always_ff @(posedge i_clk_24) begin
        if (wr_ok) begin
            mem[wp_q] <= i_data;
        end
    end

    // Registered read port; non-blocking read of the old word gives read-first at wp == rp
    always_ff @(posedge i_clk_24) begin
        if (i_rst) begin
            data_q <= '0;
        end else if (rd_ok) begin
            data_q <= mem[rp_q];
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_empty       = empty_q;
    assign o_full        = full_q;
    assign o_almost_full = af_q;
    assign o_count       = count_q;
    assign o_overflow    = ovf_q;
    assign o_underflow   = udf_q;

endmodule

// File: tb/tb_morse_fifo.sv
// Bench for morse_fifo (DEPTH 8, almost-full at 6). The driver keeps a queue
// model of the FIFO contents and pushes expected read data into a scoreboard;
// a monitor on the falling edge compares every output against the model.
module tb_morse_fifo;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_wr = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_rd = 1'b0;
    logic       i_clr_err = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_empty, o_full, o_almost_full, o_overflow, o_underflow;
    logic [3:0] o_count;

    always #21 clk = ~clk;

    morse_fifo #(.DATA_W(8), .ADDR_W(3), .AF_MARGIN(2)) dut (
        .i_clk_24     (clk),
        .i_rst        (i_rst),
        .i_wr         (i_wr),
        .i_data       (i_data),
        .i_rd         (i_rd),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_almost_full(o_almost_full),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_underflow  (o_underflow),
        .i_clr_err    (i_clr_err)
    );

    logic [7:0] mq[$];
    logic [7:0] sb[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] m_hold = 8'h00;
    bit         mon_en = 1'b0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model advances at the rising edge.
    task automatic step(input bit wr, input logic [7:0] d, input bit rd,
                        input bit clr, input bit rst);
        bit full, empty, rok, wok;
        logic [7:0] v;
        i_wr = wr; i_data = d; i_rd = rd; i_clr_err = clr; i_rst = rst;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_hold = 8'h00;
        end else begin
            full  = (mq.size() == 8);
            empty = (mq.size() == 0);
            rok   = rd && !empty;
            wok   = wr && (!full || rok);
            m_valid = rok;
            if (rok) begin
                v = mq.pop_front();
                sb.push_back(v);
                m_hold = v;
            end
            if (wok) mq.push_back(d);
            m_ovf = (m_ovf && !clr) || (wr && !wok);
            m_udf = (m_udf && !clr) || (rd && !rok);
        end
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Monitor: status against the model, read data against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(o_count), 32'(mq.size()));
            chk("empty", 32'(o_empty), 32'(mq.size() == 0));
            chk("full", 32'(o_full), 32'(mq.size() == 8));
            chk("almost_full", 32'(o_almost_full), 32'(mq.size() >= 6));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
            chk("underflow", 32'(o_underflow), 32'(m_udf));
            chk("valid", 32'(o_valid), 32'(m_valid));
            if (o_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL data: o_valid with no word expected, actual=%0h", o_data);
                end else begin
                    chk("data", 32'(o_data), 32'(sb.pop_front()));
                end
            end else begin
                chk("data_hold", 32'(o_data), 32'(m_hold));
            end
        end
    end

    initial begin
        int wn;
        int guard;
        bit w, r;

        // reset
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);

        // fill with 0x41..0x48, then drain
        for (int i = 0; i < 8; i++) step(1, 8'(8'h41 + i), 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // fill 0..7, ninth write dropped and flagged, then clear
        for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'h99, 0, 0, 0);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        step(0, 8'h00, 0, 1, 0);
        chk("ovf_clr", 32'(o_overflow), 32'd0);

        // simultaneous read and write while full, then drain
        step(1, 8'hAA, 1, 0, 0);
        chk("rw_full_data", 32'(o_data), 32'h00);
        chk("rw_full_count", 32'(o_count), 32'd8);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // underflow after reset, then write+read while empty
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("udf_set", 32'(o_underflow), 32'd1);
        step(1, 8'h3C, 1, 0, 0);
        chk("rw_empty_count", 32'(o_count), 32'd1);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0);

        // wrap-around: 20 words, interleaved reads, count kept <= 5
        wn = 0;
        guard = 0;
        while ((wn < 20 || mq.size() > 0) && guard < 500) begin
            w = (wn < 20) && (mq.size() < 5) && ($urandom_range(0, 2) != 0);
            r = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            step(w, 8'(8'h60 + wn), r, 0, 0);
            if (w) wn++;
            guard++;
        end
        chk("wrap_words", 32'(wn), 32'd20);
        step(0, 8'h00, 0, 0, 0);
        chk("wrap_no_ovf", 32'(o_overflow), 32'd0);
        chk("wrap_no_udf", 32'(o_underflow), 32'd0);

        // reset mid-stream with a read strobe held high
        for (int i = 0; i < 3; i++) step(1, 8'(8'hB0 + i), 0, 0, 0);
        step(0, 8'h00, 1, 0, 1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        step(1, 8'h5A, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // random soak: write-heavy then read-heavy, occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            w = (i < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
            r = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            step(w, 8'($urandom), r, $urandom_range(0, 15) == 0, $urandom_range(0, 80) == 0);
        end
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_fifo.md
# morse_fifo

Parametrised synchronous FIFO that replaces the single-port UART receive buffer with a self-contained queue. Unlike that buffer, it tracks both read and write pointers internally. It provides full/empty/almost-full status and a fill count, and it detects overflow and underflow. It sits between the UART receiver (writer) and the Morse encoder (reader). Both sides use a simple strobe interface on the single system clock.

## Interface

Parameters:
- DATA_W, 8: width of each stored word.
- ADDR_W, 11: pointer width; depth DEPTH = 2^ADDR_W words.
- AF_MARGIN, 4: o_almost_full asserts when count >= DEPTH - AF_MARGIN; legal range 1..DEPTH-1.

Ports:
- i_clk_24  in  1  24 MHz system clock; all logic on its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_wr  in  1  write strobe; one word pushed per cycle it is high and accepted.
- i_data  in  DATA_W  write data, sampled with i_wr.
- i_rd  in  1  read strobe; one word popped per cycle it is high and accepted.
- o_data  out  DATA_W  read data; holds the last popped word until the next accepted pop.
- o_valid  out  1  one-cycle pulse marking a new word on o_data.
- o_empty  out  1  count == 0.
- o_full  out  1  count == DEPTH.
- o_almost_full  out  1  count >= DEPTH - AF_MARGIN.
- o_count  out  ADDR_W+1  words currently stored, 0..DEPTH.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.
- i_clr_err  in  1  clears both sticky error flags.

## Operation

- State: write pointer wp and read pointer rp, each ADDR_W bits; count register ADDR_W+1 bits. Both pointers wrap modulo DEPTH naturally; no special handling at DEPTH-1 -> 0.
- Storage: inferred single-clock dual-port block RAM of DEPTH x DATA_W, with one write port and one registered read port.
- Write acceptance: wr_ok = i_wr & (!o_full | rd_ok). An accepted write stores i_data at wp and increments wp.
- Read acceptance: rd_ok = i_rd & !o_empty. An accepted read fetches mem[rp] and increments rp.
- Count update: +1 when only wr_ok is true, -1 when only rd_ok is true, unchanged when both or neither are true.
- Simultaneous read and write while full: both are accepted, and wp == rp at that point. The read must return the old contents of the entry, not i_data (read-first behaviour, or an equivalent bypass).
- Simultaneous read and write while empty: the write is accepted, the read is rejected and sets o_underflow. The new word is not forwarded.
- Rejected write (full, no accepted read): data is dropped, pointers are unchanged, and o_overflow is set.
- Rejected read (empty): nothing is fetched, o_valid stays low, and o_underflow is set.
- Error flags: set by the event and held until i_clr_err or i_rst. If an error event and i_clr_err occur in the same cycle, the flag ends set.
- Status flags (o_empty, o_full, o_almost_full) are registered and derived from the next-state count, so they are valid in the same cycle as the updated o_count.
- Reset: wp = 0, rp = 0, count = 0, o_data = 0, o_valid = 0, o_empty = 1, o_full = 0, o_almost_full = 0, o_overflow = 0, o_underflow = 0. Memory contents are not cleared.
- Reset mid-operation: a strobe in the reset cycle is ignored. The queue restarts empty on the next cycle, and no o_valid is emitted for a read in flight.

## Timing

- Write latency: i_wr accepted at edge N updates o_count and o_empty at N+1. The word can be popped by i_rd sampled at N+1.
- Read latency: i_rd accepted at edge N produces o_data and o_valid after edge N+1, i.e. one cycle of latency. Back-to-back reads sustain one word per cycle.
- Write-to-data latency: a write at N into an empty FIFO, followed by a read at N+1, gives o_valid after N+2.
- Throughput: one write and one read per cycle, concurrently.
- There are no combinational paths from inputs to outputs.

## Test plan

- Reset then fill: write 0x41..0x48 (8 words) on consecutive cycles, then read 8 times. Required: o_valid pulses with 0x41..0x48 in order, o_count goes 8 -> 0, o_empty returns high.
- Full and overflow (ADDR_W=3, AF_MARGIN=2): write 9 words. Required: o_almost_full high at count 6, o_full high at count 8, 9th word dropped, o_overflow = 1. Then pulse i_clr_err; required: o_overflow = 0.
- Simultaneous read/write at full (ADDR_W=3): fill with 0..7, then assert i_wr = 1 (data 0xAA) and i_rd = 1. Required: o_data = 0x00, o_count stays 8. Draining then yields 1..7 followed by 0xAA.
- Underflow: after reset, pulse i_rd. Required: o_valid stays 0, o_underflow = 1, o_count = 0. Then write+read in the same cycle; required: count ends at 1.
- Wrap-around (ADDR_W=3): stream 20 words with interleaved reads, keeping count <= 5. Required: all 20 words are read back in order with no error flags.
- Reset mid-stream: with 3 words stored and i_rd high, assert i_rst for one cycle. Required: no o_valid, o_count = 0, o_empty = 1 on the next cycle; the next write/read round-trips correctly.
